// File: rtl/eth_sw_pkt_arb.sv
// eth_sw_pkt_arb: packet-atomic round-robin arbiter that shares the single
// eth_sw ingress port between NUM_REQ packet sources. A grant is held from
// the SOP beat through the EOP beat, so packets never interleave. The output
// is one register stage deep, and sources are back-pressured through reqRdy.
// Optional feature: define ARB_PKT_STATS_EN to add per-source 16-bit packet
// counters on port pktCnt.
module eth_sw_pkt_arb #(
  parameter int NUM_REQ = 4,
  parameter int DW      = 64
) (
  input  logic                       clk,
  input  logic                       resetN,
  input  logic [NUM_REQ*DW-1:0]      reqData,
  input  logic [NUM_REQ-1:0]         reqSop,
  input  logic [NUM_REQ-1:0]         reqEop,
  input  logic [NUM_REQ-1:0]         reqVld,
  output logic [NUM_REQ-1:0]         reqRdy,
  output logic [DW-1:0]              outData,
  output logic                       outSop,
  output logic                       outEop,
  output logic                       outVld,
  input  logic                       outRdy,
  output logic [$clog2(NUM_REQ)-1:0] gntId,
  output logic                       protoErr
`ifdef ARB_PKT_STATS_EN
  ,
  output logic [NUM_REQ*16-1:0]      pktCnt
`endif
);

  localparam int GW = $clog2(NUM_REQ);

  typedef enum logic {IDLE, XFER} state_t;

  state_t              state, state_nxt;
  logic [GW-1:0]       gnt_p0, gnt_nxt;
  logic                first_beat, first_nxt;
  logic                perr_nxt;
  logic                can_load;
  logic                accept;
  logic [NUM_REQ-1:0]  cand, stray, stray_sel, rdy;
  logic                sel_vld, sel_sop, sel_eop;
  logic [DW-1:0]       sel_data;

  logic [DW-1:0]       data_p1;
  logic                sop_p1, eop_p1, vld_p1;

  // Round-robin search starting after the last grant; the wrap from
  // NUM_REQ-1 back to 0 is explicit so non-power-of-two counts work.
  function automatic logic [GW-1:0] rr_pick(input logic [NUM_REQ-1:0] c,
                                            input logic [GW-1:0] last);
    logic [GW-1:0] idx;
    logic [GW-1:0] win;
    logic          hit;
    idx = last;
    win = last;
    hit = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (idx == GW'(NUM_REQ - 1)) ? '0 : idx + GW'(1);
      if (!hit && c[idx]) begin
        win = idx;
        hit = 1'b1;
      end
    end
    return win;
  endfunction

  // One-hot of the lowest set bit; stray beats are drained lowest index first.
  function automatic logic [NUM_REQ-1:0] lowest_one(input logic [NUM_REQ-1:0] v);
    logic [NUM_REQ-1:0] r;
    logic               hit;
    r   = '0;
    hit = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!hit && v[k]) begin
        r[k] = 1'b1;
        hit  = 1'b1;
      end
    end
    return r;
  endfunction

  assign can_load  = !vld_p1 || outRdy;
  assign cand      = reqVld & reqSop;
  assign stray     = reqVld & ~reqSop;
  assign stray_sel = lowest_one(stray);

  assign sel_vld  = reqVld[gnt_p0];
  assign sel_sop  = reqSop[gnt_p0];
  assign sel_eop  = reqEop[gnt_p0];
  assign sel_data = reqData[int'(gnt_p0) * DW +: DW];

  // Nothing is accepted from any source while reset is held.
  assign reqRdy = rdy & {NUM_REQ{resetN}};

  // Next-state, grant selection, per-source ready and protocol-error detect.
  always_comb begin
    state_nxt = state;
    gnt_nxt   = gnt_p0;
    first_nxt = first_beat;
    rdy       = '0;
    perr_nxt  = 1'b0;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        // A beat without SOP outside a packet is discarded and flagged.
        rdy = stray_sel;
        if (|stray_sel) perr_nxt = 1'b1;
        // Arbitration cycle: grant only, no beat taken (one bubble/packet).
        if (|cand) begin
          gnt_nxt   = rr_pick(cand, gnt_p0);
          first_nxt = 1'b1;
          state_nxt = XFER;
        end
      end
      XFER: begin
        rdy[gnt_p0] = can_load;
        accept      = sel_vld && can_load;
        if (accept) begin
          first_nxt = 1'b0;
          if (sel_sop && !first_beat) perr_nxt = 1'b1;
          if (sel_eop) state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // FSM, grant and error-pulse registers.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state      <= IDLE;
      gnt_p0     <= GW'(NUM_REQ - 1);
      first_beat <= 1'b0;
      protoErr   <= 1'b0;
    end else begin
      state      <= state_nxt;
      gnt_p0     <= gnt_nxt;
      first_beat <= first_nxt;
      protoErr   <= perr_nxt;
    end
  end

  // ---- stage p1: registered output toward eth_sw ----
  // Output register loads an accepted beat, drains when the sink takes it,
  // and holds while the sink stalls.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      data_p1 <= '0;
      sop_p1  <= 1'b0;
      eop_p1  <= 1'b0;
      vld_p1  <= 1'b0;
    end else if (accept) begin
      data_p1 <= sel_data;
      sop_p1  <= sel_sop && first_beat;
      eop_p1  <= sel_eop;
      vld_p1  <= 1'b1;
    end else if (can_load) begin
      sop_p1  <= 1'b0;
      eop_p1  <= 1'b0;
      vld_p1  <= 1'b0;
    end
  end

  assign outData = data_p1;
  assign outSop  = sop_p1;
  assign outEop  = eop_p1;
  assign outVld  = vld_p1;
  assign gntId   = gnt_p0;

`ifdef ARB_PKT_STATS_EN
  logic [15:0] pkt_cnt [NUM_REQ];

  // Per-source completed-packet counters, bumped on each accepted EOP beat.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      for (int i = 0; i < NUM_REQ; i++) pkt_cnt[i] <= '0;
    end else if (accept && sel_eop) begin
      pkt_cnt[gnt_p0] <= pkt_cnt[gnt_p0] + 16'd1;
    end
  end

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_cnt
    assign pktCnt[g*16 +: 16] = pkt_cnt[g];
  end
`endif

endmodule

// File: tb/tb_eth_sw_pkt_arb.sv
// Testbench for eth_sw_pkt_arb: per-source beat queues feed the sources,
// expected output beats go into a scoreboard queue, and a monitor pops and
// compares on every output handshake. Works with or without ARB_PKT_STATS_EN.
module tb_eth_sw_pkt_arb;
  localparam int NUM_REQ = 4;
  localparam int DW      = 64;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          sop;
    logic          eop;
  } beat_t;

  logic                  clk = 1'b0;
  logic                  resetN = 1'b0;
  logic [NUM_REQ*DW-1:0] reqData = '0;
  logic [NUM_REQ-1:0]    reqSop = '0;
  logic [NUM_REQ-1:0]    reqEop = '0;
  logic [NUM_REQ-1:0]    reqVld = '0;
  logic [NUM_REQ-1:0]    reqRdy;
  logic [DW-1:0]         outData;
  logic                  outSop, outEop, outVld;
  logic                  outRdy = 1'b1;
  logic [1:0]            gntId;
  logic                  protoErr;
`ifdef ARB_PKT_STATS_EN
  logic [NUM_REQ*16-1:0] pktCnt;
`endif

  beat_t src_q [NUM_REQ][$];
  beat_t exp_q [$];
  int    acc_cnt [NUM_REQ];
  int    checks = 0;
  int    errors = 0;
  int    vld_cycles = 0;
  int    perr_cnt = 0;
  logic [NUM_REQ-1:0] hs;

  eth_sw_pkt_arb #(.NUM_REQ(NUM_REQ), .DW(DW)) dut (
    .clk(clk), .resetN(resetN),
    .reqData(reqData), .reqSop(reqSop), .reqEop(reqEop), .reqVld(reqVld),
    .reqRdy(reqRdy),
    .outData(outData), .outSop(outSop), .outEop(outEop), .outVld(outVld),
    .outRdy(outRdy), .gntId(gntId), .protoErr(protoErr)
`ifdef ARB_PKT_STATS_EN
    , .pktCnt(pktCnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic add_src(input int s, input logic [63:0] base, input int n);
    beat_t b;
    for (int k = 0; k < n; k++) begin
      b.data = base + 64'(k);
      b.sop  = (k == 0);
      b.eop  = (k == n - 1);
      src_q[s].push_back(b);
    end
  endtask

  task automatic add_exp(input logic [63:0] base, input int n);
    beat_t b;
    for (int k = 0; k < n; k++) begin
      b.data = base + 64'(k);
      b.sop  = (k == 0);
      b.eop  = (k == n - 1);
      exp_q.push_back(b);
    end
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(posedge clk);
      n++;
    end
    repeat (4) @(posedge clk);
    #2;
    chk(name, 64'(exp_q.size()), 64'd0);
  endtask

  // Source driver: handshakes are sampled at the falling edge, queues are
  // advanced and the next beat presented just after the rising edge.
  always begin
    @(negedge clk);
    hs = reqVld & reqRdy;
    @(posedge clk);
    #1;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (hs[i] && src_q[i].size() > 0) begin
        void'(src_q[i].pop_front());
        acc_cnt[i]++;
      end
      if (src_q[i].size() > 0) begin
        reqVld[i] = 1'b1;
        reqSop[i] = src_q[i][0].sop;
        reqEop[i] = src_q[i][0].eop;
        reqData[i*DW +: DW] = src_q[i][0].data;
      end else begin
        reqVld[i] = 1'b0;
        reqSop[i] = 1'b0;
        reqEop[i] = 1'b0;
      end
    end
  end

  // Output monitor / scoreboard.
  always @(negedge clk) begin
    beat_t e;
    if (resetN) begin
      if (outVld) vld_cycles++;
      if (protoErr) perr_cnt++;
      if (outVld && outRdy) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat got=%0h exp=none", outData);
        end else begin
          e = exp_q.pop_front();
          chk("beat_data", outData, e.data);
          chk("beat_sop", 64'(outSop), 64'(e.sop));
          chk("beat_eop", 64'(outEop), 64'(e.eop));
        end
      end
    end
  end

  initial begin
    int   v0, p0, base;
    bit   seen;
    beat_t b;

    for (int i = 0; i < NUM_REQ; i++) acc_cnt[i] = 0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_outVld", 64'(outVld), 64'd0);
    chk("rst_outSop", 64'(outSop), 64'd0);
    chk("rst_outEop", 64'(outEop), 64'd0);
    chk("rst_outData", outData, 64'd0);
    chk("rst_reqRdy", 64'(reqRdy), 64'd0);
    chk("rst_gntId", 64'(gntId), 64'd3);
    chk("rst_protoErr", 64'(protoErr), 64'd0);
`ifdef ARB_PKT_STATS_EN
    chk("rst_pktCnt", 64'(pktCnt), 64'd0);
`endif
    @(negedge clk);
    resetN = 1'b1;
    @(posedge clk);
    #2;

    // Test 1: src0 three-beat packet
    v0 = vld_cycles;
    add_src(0, 64'hA0, 3);
    add_exp(64'hA0, 3);
    wait_drain("t1_drain");
    chk("t1_vld_cycles", 64'(vld_cycles - v0), 64'd3);
    chk("t1_gntId", 64'(gntId), 64'd0);

    // Test 5: single-beat src3 wins over pending src0 (search starts at 1)
    add_src(3, 64'h55, 1);
    add_src(0, 64'hB0, 2);
    add_exp(64'h55, 1);
    add_exp(64'hB0, 2);
    wait_drain("t5_drain");
    chk("t5_gntId", 64'(gntId), 64'd0);

    // Test 3: src1 four-beat packet with a two-cycle output stall
    add_src(1, 64'hC0, 4);
    add_exp(64'hC0, 4);
    seen = 1'b0;
    for (int n = 0; n < 50 && !seen; n++) begin
      @(negedge clk);
      if (outVld && outSop && outData == 64'hC0) seen = 1'b1;
    end
    chk("t3_sop_seen", 64'(seen), 64'd1);
    @(posedge clk);
    #1;
    outRdy = 1'b0;
    for (int n = 0; n < 2; n++) begin
      @(negedge clk);
      chk("t3_hold_data", outData, 64'hC1);
      chk("t3_hold_vld", 64'(outVld), 64'd1);
      chk("t3_stall_rdy", 64'(reqRdy[1]), 64'd0);
    end
    @(posedge clk);
    #1;
    outRdy = 1'b1;
    wait_drain("t3_drain");
    chk("t3_gntId", 64'(gntId), 64'd1);

    // Test 4: stray beat on src2 while idle
    p0 = perr_cnt;
    b.data = 64'hDEAD;
    b.sop  = 1'b0;
    b.eop  = 1'b0;
    src_q[2].push_back(b);
    @(posedge clk);
    #2;
    @(negedge clk);
    chk("t4_stray_rdy", 64'(reqRdy[2]), 64'd1);
    repeat (5) @(posedge clk);
    #2;
    chk("t4_perr_pulses", 64'(perr_cnt - p0), 64'd1);
    chk("t4_drained", 64'(src_q[2].size()), 64'd0);
    chk("t4_outVld", 64'(outVld), 64'd0);

    // Test 6: async reset after beat 2 of 5 of a src1 packet
    base = acc_cnt[1];
    add_src(1, 64'hE0, 5);
    b.data = 64'hE0;
    b.sop  = 1'b1;
    b.eop  = 1'b0;
    exp_q.push_back(b);
    seen = 1'b0;
    for (int n = 0; n < 50 && !seen; n++) begin
      @(posedge clk);
      #2;
      if (acc_cnt[1] >= base + 2) seen = 1'b1;
    end
    chk("t6_two_beats", 64'(seen), 64'd1);
    src_q[1].delete();
    resetN = 1'b0;
    #1;
    chk("t6_outVld", 64'(outVld), 64'd0);
    chk("t6_gntId", 64'(gntId), 64'd3);
    chk("t6_e0_out", 64'(exp_q.size()), 64'd0);
`ifdef ARB_PKT_STATS_EN
    chk("t6_pktCnt_rst", 64'(pktCnt), 64'd0);
`endif
    repeat (2) @(posedge clk);
    @(negedge clk);
    resetN = 1'b1;
    @(posedge clk);
    #2;
    add_src(1, 64'hF0, 2);
    add_exp(64'hF0, 2);
    wait_drain("t6_drain");
    chk("t6_gntId_after", 64'(gntId), 64'd1);
`ifdef ARB_PKT_STATS_EN
    chk("t6_pktCnt1", 64'(pktCnt[16 +: 16]), 64'd1);
    chk("t6_pktCnt0", 64'(pktCnt[0 +: 16]), 64'd0);
`endif

    // Test 2: all sources hold two 2-beat packets each, from a fresh reset
    @(negedge clk);
    resetN = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    resetN = 1'b1;
    #1;
    chk("t2_gntId_rst", 64'(gntId), 64'd3);
    @(posedge clk);
    #2;
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < NUM_REQ; i++)
        add_src(i, 64'h1000 + 64'(i * 256) + 64'(r * 16), 2);
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < NUM_REQ; i++)
        add_exp(64'h1000 + 64'(i * 256) + 64'(r * 16), 2);
    wait_drain("t2_drain");
    chk("t2_gntId", 64'(gntId), 64'd3);

    chk("perr_total", 64'(perr_cnt), 64'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "time limit");
  end

endmodule
